// File: rtl/adder_share_sched.sv
// adder_share_sched: round-robin scheduler time-sharing one external adder for narrow and wide add/sub.
module adder_share_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 16,
  parameter int ID_W = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_wide,
  input  logic [NUM_REQ-1:0]         req_sub,
  input  logic [NUM_REQ*2*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*2*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  output logic                       add_cin,
  input  logic [WIDTH-1:0]           add_sum,
  input  logic                       add_cout,
  input  logic                       add_zero,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [2*WIDTH-1:0]         rsp_result,
  output logic                       rsp_carry,
  output logic                       rsp_zero
);
  typedef enum logic [1:0] {IDLE, EXEC_LO, EXEC_HI, RESP} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] rr_ptr, gnt;
  logic found, sel_wide, sel_sub;
  logic [2*NUM_REQ-1:0] rot;
  logic [2*WIDTH-1:0] a_q, b_q, sel_a, sel_b;
  logic wide_q, sub_q;
  int t;
  always_comb begin
    found = 1'b0;
    gnt = '0;
    t = 0;
    rot = {req_valid, req_valid} >> rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        t = int'(rr_ptr) + k;
        t = t >= NUM_REQ ? t - NUM_REQ : t;
        gnt = ID_W'(t);
      end
    end
  end
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_wide = 1'b0;
    sel_sub = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == gnt) begin
        sel_a = req_a[i*2*WIDTH +: 2*WIDTH];
        sel_b = req_b[i*2*WIDTH +: 2*WIDTH];
        sel_wide = req_wide[i];
        sel_sub = req_sub[i];
      end
    end
  end
  // req_ready is gated by reset so nothing looks accepted while the block is held in reset
  always_comb begin
    req_ready = (reset_n && state == IDLE && found) ? NUM_REQ'(1) << gnt : '0;
    rsp_valid = state == RESP;
    add_a = state == EXEC_LO ? a_q[WIDTH-1:0] : state == EXEC_HI ? a_q[2*WIDTH-1:WIDTH] : '0;
    add_b = state == EXEC_LO ? b_q[WIDTH-1:0] ^ {WIDTH{sub_q}} :
            state == EXEC_HI ? b_q[2*WIDTH-1:WIDTH] ^ {WIDTH{sub_q}} : '0;
    add_cin = state == EXEC_LO ? sub_q : (state == EXEC_HI) & rsp_carry;
    state_nx = state == IDLE ? (found ? EXEC_LO : IDLE) :
               state == EXEC_LO ? (wide_q ? EXEC_HI : RESP) :
               state == EXEC_HI ? RESP : (rsp_ready ? IDLE : RESP);
  end
  // rsp_carry doubles as the carry latched between the low and high passes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      a_q <= '0;
      b_q <= '0;
      wide_q <= 1'b0;
      sub_q <= 1'b0;
      rsp_id <= '0;
      rsp_result <= '0;
      rsp_carry <= 1'b0;
      rsp_zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        a_q <= sel_a;
        b_q <= sel_b;
        wide_q <= sel_wide;
        sub_q <= sel_sub;
        rsp_id <= gnt;
        rr_ptr <= gnt == ID_W'(NUM_REQ - 1) ? '0 : gnt + 1'b1;
      end
      if (state == EXEC_LO) begin
        rsp_result <= {{WIDTH{1'b0}}, add_sum};
        rsp_carry <= add_cout;
        rsp_zero <= add_zero;
      end
      if (state == EXEC_HI) begin
        rsp_result[2*WIDTH-1:WIDTH] <= add_sum;
        rsp_carry <= add_cout;
        rsp_zero <= rsp_zero & add_zero;
      end
    end
  end
endmodule

// File: tb/tb_adder_share_sched.sv
// tb_adder_share_sched: directed bench with an arithmetic reference model and per-cycle response checking.
module tb_adder_share_sched;
  localparam int N = 4;
  localparam int W = 16;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, req_wide = '0, req_sub = '0;
  logic [N*2*W-1:0] req_a, req_b;
  logic [31:0] op_a [N], op_b [N];
  logic [W-1:0] add_a, add_b, add_sum;
  logic add_cin, add_cout, add_zero;
  logic rsp_valid, rsp_ready = 1'b0, rsp_carry, rsp_zero;
  logic [1:0] rsp_id;
  logic [2*W-1:0] rsp_result;
  int errors = 0, checks = 0, cyc = 0;
  typedef struct {logic [1:0] id; logic [31:0] r; logic c; logic z; int due;} exp_t;
  exp_t q[$];
  int gnt_log[$];
  bit seen = 0;

  adder_share_sched dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wide(req_wide), .req_sub(req_sub), .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
    .add_cout(add_cout), .add_zero(add_zero), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'h0, add_cin};
  assign add_zero = add_sum == '0;
  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = op_a[i];
      req_b[i*32 +: 32] = op_b[i];
    end
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic fail(input string n);
    checks++;
    errors++;
    $display("FAIL %s: timed out (cycle %0d)", n, cyc);
  endtask

  function automatic exp_t model(input int i);
    exp_t e;
    logic [32:0] s;
    logic [16:0] n;
    logic [31:0] a, b;
    a = op_a[i];
    b = op_b[i];
    e.id = 2'(i);
    if (req_wide[i]) begin
      s = req_sub[i] ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
      e.r = s[31:0];
      e.c = req_sub[i] ? a >= b : s[32];
    end else begin
      n = req_sub[i] ? {1'b0, a[15:0]} - {1'b0, b[15:0]} : {1'b0, a[15:0]} + {1'b0, b[15:0]};
      e.r = {16'h0, n[15:0]};
      e.c = req_sub[i] ? a[15:0] >= b[15:0] : n[16];
    end
    e.z = e.r == 0;
    e.due = cyc + (req_wide[i] ? 3 : 2);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      seen = 0;
    end else begin
      chk("ready_onehot", 64'($onehot0(req_ready)), 1);
      if (rsp_valid) begin
        chk("ready_busy", 64'(req_ready), 0);
        if (q.size() == 0) begin
          fail("rsp_unexpected");
        end else begin
          chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
          chk("rsp_result", 64'(rsp_result), 64'(q[0].r));
          chk("rsp_carry", 64'(rsp_carry), 64'(q[0].c));
          chk("rsp_zero", 64'(rsp_zero), 64'(q[0].z));
          if (!seen) chk("latency", 64'(cyc), 64'(q[0].due));
          seen = 1;
          if (rsp_ready) begin
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) begin
          q.push_back(model(i));
          gnt_log.push_back(i);
        end
    end
  end

  task automatic issue(input int i, input logic w, input logic s, input logic [31:0] a, input logic [31:0] b);
    int k;
    @(posedge clk); #1;
    op_a[i] = a;
    op_b[i] = b;
    req_wide[i] = w;
    req_sub[i] = s;
    req_valid[i] = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[i]) break;
    end
    if (k == 20) fail("grant_wait");
    else chk("grant", 64'(req_ready), 64'(4'b1 << i));
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp();
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    if (k == 20) fail("rsp_wait");
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    if (k == 100) fail("drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 0);
    chk("reset_req_ready", 64'(req_ready), 0);
    chk("reset_result", 64'(rsp_result), 0);
    chk("reset_id", 64'(rsp_id), 0);
    chk("reset_add_a", 64'(add_a), 0);
    chk("reset_add_cin", 64'(add_cin), 0);
    req_valid = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    rsp_ready = 1'b1;

    issue(0, 1'b0, 1'b0, 32'h0001, 32'hFFFF);
    wait_rsp();
    chk("narrow_add_result", 64'(rsp_result), 0);
    chk("narrow_add_carry", 64'(rsp_carry), 1);
    chk("narrow_add_zero", 64'(rsp_zero), 1);
    chk("narrow_add_id", 64'(rsp_id), 0);

    issue(2, 1'b0, 1'b1, 32'h0005, 32'h0007);
    wait_rsp();
    chk("narrow_sub_result", 64'(rsp_result), 64'h0000FFFE);
    chk("narrow_sub_carry", 64'(rsp_carry), 0);
    chk("narrow_sub_zero", 64'(rsp_zero), 0);
    chk("narrow_sub_id", 64'(rsp_id), 2);

    issue(1, 1'b1, 1'b0, 32'h0000FFFF, 32'h00000001);
    @(negedge clk);
    chk("wide_lo_add_a", 64'(add_a), 64'hFFFF);
    chk("wide_lo_cin", 64'(add_cin), 0);
    @(negedge clk);
    chk("wide_hi_add_a", 64'(add_a), 0);
    chk("wide_hi_cin", 64'(add_cin), 1);
    wait_rsp();
    chk("wide_add_result", 64'(rsp_result), 64'h00010000);
    chk("wide_add_carry", 64'(rsp_carry), 0);
    chk("wide_add_id", 64'(rsp_id), 1);
    drain();

    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_pulse_valid", 64'(rsp_valid), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    gnt_log.delete();
    op_a[0] = 32'h0000_1111; op_b[0] = 32'h0000_2222; req_wide[0] = 1'b0; req_sub[0] = 1'b0;
    op_a[1] = 32'h8000_0000; op_b[1] = 32'h8000_0000; req_wide[1] = 1'b1; req_sub[1] = 1'b0;
    op_a[2] = 32'h0000_0003; op_b[2] = 32'h0001_0004; req_wide[2] = 1'b1; req_sub[2] = 1'b1;
    op_a[3] = 32'h0000_4444; op_b[3] = 32'h0000_4444; req_wide[3] = 1'b0; req_sub[3] = 1'b1;
    req_valid = 4'hF;
    for (k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (gnt_log.size() >= 5) break;
    end
    req_valid = '0;
    if (k == 60) fail("rr_wait");
    else for (int i = 0; i < 5; i++) chk("rr_order", 64'(gnt_log[i]), 64'(i % 4));
    drain();

    rsp_ready = 1'b0;
    issue(1, 1'b0, 1'b0, 32'h1234, 32'h0F0F);
    op_a[3] = 32'h0001_0000; op_b[3] = 32'h0000_0001; req_wide[3] = 1'b1; req_sub[3] = 1'b1;
    req_valid[3] = 1'b1;
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(rsp_valid), 1);
      chk("bp_result", 64'(rsp_result), 64'h2143);
      chk("bp_ready", 64'(req_ready), 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_req3_grant", 64'(req_ready), 64'h8);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    wait_rsp();
    chk("wide_sub_result", 64'(rsp_result), 64'h0000FFFF);
    chk("wide_sub_carry", 64'(rsp_carry), 1);
    chk("wide_sub_id", 64'(rsp_id), 3);
    drain();

    issue(2, 1'b1, 1'b0, 32'h1234_5678, 32'h1111_1111);
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midop_rsp_valid", 64'(rsp_valid), 0);
    chk("midop_add_a", 64'(add_a), 0);
    chk("midop_ready", 64'(req_ready), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    op_a[0] = 32'h0000_0010; op_b[0] = 32'h0000_0020; req_wide[0] = 1'b0; req_sub[0] = 1'b0;
    op_a[3] = 32'h0000_0000; op_b[3] = 32'h0000_0000; req_wide[3] = 1'b0; req_sub[3] = 1'b0;
    req_valid = 4'b1001;
    @(negedge clk);
    chk("midop_first_grant", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[3]) break;
    end
    if (k == 20) fail("midop_req3_wait");
    @(posedge clk); #1;
    req_valid = '0;
    drain();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adder_share_sched.md
Name: adder_share_sched

Overview:
- Sequences one shared external WIDTH-bit ripple adder between NUM_REQ requesters, e.g. the EX-stage ALU, branch-target calc and address-gen units.
- Round-robin arbitration with a valid/ready handshake per requester.
- Supports narrow (WIDTH) and wide (2*WIDTH, two adder passes with latched carry) add/subtract.
- Returns one registered response with result, carry and zero flags and the requester id.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 16, width of the shared adder.
- ID_W, 2, width of requester id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_wide  in  NUM_REQ  1 = 2*WIDTH operation, 0 = WIDTH operation.
- req_sub  in  NUM_REQ  1 = a-b, 0 = a+b.
- req_a  in  NUM_REQ*2*WIDTH  operand A, requester i at bits [i*2*WIDTH +: 2*WIDTH].
- req_b  in  NUM_REQ*2*WIDTH  operand B, same packing as req_a.
- add_a  out  WIDTH  shared adder operand A.
- add_b  out  WIDTH  shared adder operand B.
- add_cin  out  1  shared adder carry-in.
- add_sum  in  WIDTH  shared adder sum (combinational from add_a/add_b/add_cin).
- add_cout  in  1  shared adder carry-out.
- add_zero  in  1  shared adder zero flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted by consumer.
- rsp_id  out  ID_W  index of the requester served.
- rsp_result  out  2*WIDTH  result; upper WIDTH bits are 0 for narrow operations.
- rsp_carry  out  1  final adder carry-out (for sub: 1 = no borrow).
- rsp_zero  out  1  1 when the full result is zero.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_zero=0, add_a/add_b/add_cin=0, req_ready=0. All internal operand/carry registers cleared.
- Reset mid-operation aborts the operation with no response. The in-flight request is lost; the requester must re-issue it.
- States: IDLE, EXEC_LO, EXEC_HI, RESP.
- IDLE:
  - Grant goes to the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready[grant]=1 combinationally in that cycle; all other bits 0.
  - On the accept edge: latch a, b, wide and sub of the granted requester; latch id; set rr_ptr=(grant+1) mod NUM_REQ; go to EXEC_LO.
  - If no valid request: stay in IDLE with rr_ptr unchanged.
- req_ready is 0 in every state other than IDLE, so no request is accepted while busy.
- EXEC_LO:
  - add_a=a[WIDTH-1:0].
  - add_b=b[WIDTH-1:0], inverted when sub=1.
  - add_cin=sub.
  - Capture add_sum into result low half, add_cout into carry register, add_zero into zlo.
  - Next state: wide ? EXEC_HI : RESP.
- EXEC_HI:
  - add_a=a[2W-1:W].
  - add_b=b[2W-1:W], inverted when sub=1.
  - add_cin=captured carry from EXEC_LO.
  - Capture sum into result high half and the new carry.
  - rsp_zero is set to zlo & add_zero.
  - Next state: RESP.
- Narrow completion: rsp_zero=zlo and result high half=0.
- add_a/add_b/add_cin are driven 0 in IDLE and RESP.
- RESP:
  - rsp_valid=1; rsp_* fields held stable until the rsp_ready=1 edge.
  - On that edge, rsp_valid falls to 0 and the state returns to IDLE.
  - A new grant is possible in the following cycle (no IDLE/RESP overlap).
- Latency, accept edge to first rsp_valid cycle: narrow 2 cycles, wide 3 cycles.
- Best-case throughput with rsp_ready held high: one narrow operation per 3 cycles, one wide per 4.
- req_valid dropping while not granted has no effect. Operands need only be stable in the accept cycle.
- Carry and overflow wrap modulo 2**(2*WIDTH); there is no overflow flag.

Test Plan:
- Reset then a single narrow add: req0 a=0x0001 b=0xFFFF -> req_ready[0] pulse, rsp_valid 2 cycles later, rsp_result=0x00000000, rsp_carry=1, rsp_zero=1, rsp_id=0.
- Narrow sub: req2 a=0x0005 b=0x0007 -> rsp_result=0x0000FFFE, rsp_carry=0 (borrow), rsp_zero=0, rsp_id=2.
- Wide add with carry propagation: req1 a=0x0000FFFF b=0x00000001 -> add_cin in EXEC_HI = 1, rsp_result=0x00010000, rsp_carry=0, latency 3.
- Round-robin fairness: all four req_valid held high with rsp_ready=1 -> grants in order 0,1,2,3,0; none starved; req_ready one-hot.
- Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_* stable, req_ready stays 0, req3 waits; req3 is granted the cycle after rsp_ready=1.
- Reset mid-op: assert reset_n=0 in EXEC_HI -> rsp_valid=0 immediately, state IDLE, rr_ptr=0; the next request from req0 is granted first.
